// File: rtl/mm2im_mapper_db.sv
// mm2im_mapper_db
//   Maps one tile of PE columns to output-map positions for a transposed
//   convolution and holds the result in a two-bank (ping-pong) snapshot
//   buffer. One bank is filled while the other is presented downstream.
//
//   For every PE p of a tile the output position is
//     o = row_id*STRIDE + tile_id*NUM_PE + p - PAD[layer_id]
//   and the PE is marked valid when 0 <= o < OUT_LEN[layer_id].
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   start            : request a new tile computation
//   start_ready      : start is accepted this cycle
//   row_id, tile_id,
//   layer_id         : tile descriptor, latched when start is accepted
//   snap_valid       : presented bank holds a complete snapshot
//   snap_ready       : consumer takes the presented snapshot
//   cmap_snapshot    : per-PE valid bits of the presented bank
//   omap_snapshot    : per-PE output positions of the presented bank
//   done_PE          : drain index into the presented bank
//   pe_valid, pe_addr: cmap/omap entry at done_PE (0 when out of range
//                      or no valid snapshot)
//   overflow         : sticky, set when a start is dropped
module mm2im_mapper_db #(
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned OMAP_W     = 14,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned NUM_LAYERS = 4,
  parameter logic [NUM_LAYERS*4-1:0]      LAYER_PAD     = 16'h0321,
  parameter logic [NUM_LAYERS*OMAP_W-1:0] LAYER_OUT_LEN = {14'd100, 14'd32, 14'd64, 14'd64}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     start_ready,
  input  logic [8:0]               row_id,
  input  logic [5:0]               tile_id,
  input  logic [1:0]               layer_id,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [NUM_PE-1:0]        cmap_snapshot,
  output logic [NUM_PE*OMAP_W-1:0] omap_snapshot,
  input  logic [4:0]               done_PE,
  output logic                     pe_valid,
  output logic [OMAP_W-1:0]        pe_addr,
  output logic                     overflow
);

  localparam int unsigned OW = OMAP_W + 2;
  localparam int unsigned PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_e;

  state_e state_q, state_d;

  // Latched tile descriptor
  logic [8:0]    row_q,   row_d;
  logic [5:0]    tile_q,  tile_d;
  logic [1:0]    layer_q, layer_d;
  logic          bank_q,  bank_d;
  logic [PW-1:0] p_q,     p_d;

  // Ping-pong banks and their control
  logic [NUM_PE-1:0]        cmap_q [2];
  logic [NUM_PE-1:0]        cmap_d [2];
  logic [NUM_PE*OMAP_W-1:0] omap_q [2];
  logic [NUM_PE*OMAP_W-1:0] omap_d [2];
  logic [1:0]               full_q,     full_d;
  logic                     fill_q,     fill_d;
  logic                     pres_q,     pres_d;
  logic                     overflow_q, overflow_d;

  // FSM outputs
  logic compute_en;
  logic commit_en;
  logic accept;
  logic consume;

  // Datapath
  logic [3:0]        pad_c;
  logic [OMAP_W-1:0] len_c;
  logic [OW-1:0]     pos_c;
  logic [OW-1:0]     o_c;
  logic              hit_c;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = COMPUTE;
      COMPUTE: if (p_q == PW'(NUM_PE - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    start_ready = 1'b0;
    compute_en  = 1'b0;
    commit_en   = 1'b0;
    unique case (state_q)
      IDLE:    start_ready = ~(full_q[0] & full_q[1]);
      COMPUTE: compute_en  = 1'b1;
      COMMIT:  commit_en   = 1'b1;
      default: ;
    endcase
  end

  assign accept  = start & start_ready;
  assign consume = snap_valid & snap_ready;

  // ---------------------------------------------------------------------------
  // Output-position datapath for PE p_q of the latched tile.
  // o_c is a two's-complement value held in OW bits; its MSB is the sign, so
  // a non-negative o_c compares correctly against OUT_LEN as unsigned.
  // ---------------------------------------------------------------------------
  always_comb begin
    pad_c = LAYER_PAD[4*int'(layer_q) +: 4];
    len_c = LAYER_OUT_LEN[OMAP_W*int'(layer_q) +: OMAP_W];
    pos_c = OW'(row_q) * OW'(STRIDE) + OW'(tile_q) * OW'(NUM_PE) + OW'(p_q);
    o_c   = pos_c - OW'(pad_c);
    hit_c = ~o_c[OW-1] && (o_c < OW'(len_c));
  end

  // ---------------------------------------------------------------------------
  // Control and bank next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    row_d      = row_q;
    tile_d     = tile_q;
    layer_d    = layer_q;
    bank_d     = bank_q;
    p_d        = p_q;
    cmap_d     = cmap_q;
    omap_d     = omap_q;
    full_d     = full_q;
    fill_d     = fill_q;
    pres_d     = pres_q;
    overflow_d = overflow_q;

    if (start && !start_ready) begin
      overflow_d = 1'b1;
    end

    if (accept) begin
      row_d   = row_id;
      tile_d  = tile_id;
      layer_d = layer_id;
      bank_d  = fill_q;
      p_d     = '0;
    end

    if (compute_en) begin
      cmap_d[bank_q][p_q] = hit_c;
      omap_d[bank_q][int'(p_q)*OMAP_W +: OMAP_W] = hit_c ? o_c[OMAP_W-1:0] : '0;
      p_d = p_q + PW'(1);
    end

    // Commit and consume may coincide: the committed bank is never the
    // presented one while the presented one is full, so both updates apply.
    if (commit_en) begin
      full_d[bank_q] = 1'b1;
      fill_d         = ~fill_q;
    end

    if (consume) begin
      full_d[pres_q] = 1'b0;
      pres_d         = ~pres_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      tile_q     <= '0;
      layer_q    <= '0;
      bank_q     <= 1'b0;
      p_q        <= '0;
      cmap_q[0]  <= '0;
      cmap_q[1]  <= '0;
      omap_q[0]  <= '0;
      omap_q[1]  <= '0;
      full_q     <= '0;
      fill_q     <= 1'b0;
      pres_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      tile_q     <= tile_d;
      layer_q    <= layer_d;
      bank_q     <= bank_d;
      p_q        <= p_d;
      cmap_q     <= cmap_d;
      omap_q     <= omap_d;
      full_q     <= full_d;
      fill_q     <= fill_d;
      pres_q     <= pres_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Presented snapshot and drain lookup
  // ---------------------------------------------------------------------------
  assign snap_valid    = full_q[pres_q];
  assign cmap_snapshot = cmap_q[pres_q];
  assign omap_snapshot = omap_q[pres_q];
  assign overflow      = overflow_q;

  always_comb begin
    pe_valid = 1'b0;
    pe_addr  = '0;
    if (snap_valid) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        if (32'(done_PE) == i) begin
          pe_valid = cmap_q[pres_q][i];
          pe_addr  = omap_q[pres_q][i*OMAP_W +: OMAP_W];
        end
      end
    end
  end

endmodule

// File: doc/mm2im_mapper_db.md
MM2IM_MAPPER_DB -- requirements
Module: mm2im_mapper_db

Interface
REQ-001 SHALL have parameter NUM_PE, default 16, the number of PE columns per tile.
REQ-002 SHALL have parameter OMAP_W, default 14, the output-position width.
REQ-003 SHALL have parameter STRIDE, default 2, the transposed-convolution stride (1..4).
REQ-004 SHALL have parameter NUM_LAYERS, default 4, the number of layer-table entries.
REQ-005 SHALL have parameter LAYER_PAD, NUM_LAYERS*4 bits, the packed per-layer padding; entry L occupies bits [4L+3:4L].
REQ-006 SHALL have parameter LAYER_OUT_LEN, NUM_LAYERS*OMAP_W bits, the packed per-layer output length.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1 bit: request a new tile snapshot.
REQ-010 SHALL have port start_ready, output, 1 bit: start accepted this cycle if high.
REQ-011 SHALL have port row_id, input, 9 bits: input row position.
REQ-012 SHALL have port tile_id, input, 6 bits: tap-group index.
REQ-013 SHALL have port layer_id, input, 2 bits: layer-table index.
REQ-014 SHALL have port snap_valid, output, 1 bit: presented snapshot valid.
REQ-015 SHALL have port snap_ready, input, 1 bit: consumer accepts the snapshot.
REQ-016 SHALL have port cmap_snapshot, output, NUM_PE bits: per-PE valid map.
REQ-017 SHALL have port omap_snapshot, output, NUM_PE*OMAP_W bits: per-PE output position; PE p occupies [p*OMAP_W +: OMAP_W].
REQ-018 SHALL have port done_PE, input, 5 bits: PE drain index 0..NUM_PE.
REQ-019 SHALL have port pe_valid, output, 1 bit: cmap bit of PE done_PE in the presented bank.
REQ-020 SHALL have port pe_addr, output, OMAP_W bits: omap entry of PE done_PE in the presented bank.
REQ-021 SHALL have port overflow, output, 1 bit: sticky, set when start is dropped.

Function
REQ-022 SHALL hold two snapshot banks (cmap + omap each), each with a full flag, a fill pointer and a present pointer.
REQ-023 SHALL use the FSM states IDLE, COMPUTE and COMMIT.
REQ-024 SHALL drive start_ready = (state==IDLE) and (at least one bank not full).
REQ-025 SHALL, on start&&start_ready in IDLE, latch row_id, tile_id, layer_id and the fill bank index, clear p, and enter COMPUTE.
REQ-026 SHALL, in COMPUTE, process one PE per cycle, p = 0..NUM_PE-1, computing o = row_id*STRIDE + (tile_id*NUM_PE + p) - PAD[layer_id] in signed arithmetic of width OMAP_W+2 bits without truncation.
REQ-027 SHALL set cmap[p] = 1 and omap[p] = o[OMAP_W-1:0] when 0 <= o < OUT_LEN[layer_id]; otherwise cmap[p] = 0 and omap[p] = 0.
REQ-028 SHALL, after p = NUM_PE-1, go to COMMIT; in COMMIT, set the fill bank's full flag, toggle the fill pointer and return to IDLE.
REQ-029 SHALL have a start-to-full latency of exactly NUM_PE+1 cycles.
REQ-030 SHALL drive snap_valid = full flag of the present bank; cmap_snapshot and omap_snapshot come straight from the present bank registers.
REQ-031 SHALL treat snap_valid&&snap_ready as the transfer: clear the present bank's full flag and toggle the present pointer next cycle.
REQ-032 SHALL keep the snapshot contents stable while snap_valid is high and snap_ready is low.
REQ-033 SHALL, on a simultaneous COMMIT and consume in the same cycle, take both actions; the banks are distinct by construction.
REQ-034 SHALL make pe_valid and pe_addr combinational from the present bank at index done_PE.
REQ-035 SHALL drive pe_valid = 0 and pe_addr = 0 when done_PE >= NUM_PE or snap_valid = 0.
REQ-036 SHALL ignore start while start_ready = 0 and set overflow to 1 until reset.
REQ-037 SHALL NOT let the layer_id, row_id or tile_id inputs affect a computation in progress once that computation is accepted.

Reset
REQ-038 SHALL, on rst high at a clock edge, force the FSM to IDLE, clear both full flags, both pointers, p and overflow, and zero both banks.
REQ-039 SHALL, after reset, drive start_ready = 1, snap_valid = 0, zero snapshots, pe_valid = 0, pe_addr = 0 and overflow = 0.
REQ-040 SHALL let rst abort a COMPUTE in progress; no partial bank becomes valid.

Verification
REQ-041 SHALL cover basic map: NUM_PE=16, STRIDE=2, PAD=1, OUT_LEN=64, row_id=3, tile_id=0, layer 0 -> after 17 cycles snap_valid=1; PE0 o=5, PE15 o=20; cmap=16'hFFFF.
REQ-042 SHALL cover boundary clipping: row_id=0, tile_id=0, PAD=2 -> cmap bits 0,1 = 0 with omap entries 0; PE2 o=0 valid. row_id=25, OUT_LEN=64 -> PEs with o>=64 have cmap=0.
REQ-043 SHALL cover double buffering: two starts with snap_ready=0 -> both banks full, start_ready=0; a third start sets overflow=1; one snap_ready pulse presents the second snapshot and start_ready returns to 1.
REQ-044 SHALL cover backpressure stability: hold snap_ready=0 for 50 cycles while input ports toggle -> snapshot outputs are bit-identical throughout.
REQ-045 SHALL cover drain lookup: done_PE sweeps 0..16 on a valid snapshot -> pe_valid/pe_addr match cmap/omap per index; done_PE=16 gives 0/0.
REQ-046 SHALL cover reset mid-compute: rst asserted at p=7 -> next cycle IDLE, snap_valid=0, overflow=0; a new start completes normally after 17 cycles.
